// File: rtl/ex_mult_pipe_if.sv
// Issue-side and result-side signals of the pipelined multiplier.
// master: issue/CDB side driving operands and taking results.
// slave:  the multiply unit.
interface ex_mult_pipe_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5,
  parameter int REG_W  = 5
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_opa;
  logic [DATA_W-1:0] in_opb;
  logic              in_hi;
  logic [TAG_W-1:0]  in_tag;
  logic [REG_W-1:0]  in_dest_reg;
  logic [DATA_W-1:0] in_npc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [REG_W-1:0]  out_dest_reg;
  logic [DATA_W-1:0] out_npc;
  logic              busy;

  modport master (
    output in_valid, in_opa, in_opb, in_hi, in_tag, in_dest_reg, in_npc,
    output flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_dest_reg, out_npc, busy
  );

  modport slave (
    input  in_valid, in_opa, in_opb, in_hi, in_tag, in_dest_reg, in_npc,
    input  flush, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_dest_reg, out_npc, busy
  );

endinterface

// File: rtl/ex_mult_pipe.sv
// Fully pipelined unsigned multiplier. Each stage consumes CHUNK bits of
// the multiplier, so the full 2*DATA_W product is ready after STAGES
// stages. Sideband (tag, dest, npc, hi) rides along with the partial
// product. Bubbles collapse: a stage advances whenever it is empty or the
// stage after it advances.
module ex_mult_pipe #(
  parameter int STAGES = 4,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5,
  parameter int REG_W  = 5
) (
  input  logic           clock,
  input  logic           reset,
  ex_mult_pipe_if.slave  bus
);

  localparam int CHUNK = DATA_W / STAGES;
  localparam int ACC_W = 2 * DATA_W;
  localparam int L     = STAGES - 1;

  // stage registers
  logic [STAGES-1:0] valid_q;
  logic [ACC_W-1:0]  opa_q  [STAGES];
  logic [DATA_W-1:0] opb_q  [STAGES];
  logic [ACC_W-1:0]  acc_q  [STAGES];
  logic [STAGES-1:0] hi_q;
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [REG_W-1:0]  dest_q [STAGES];
  logic [DATA_W-1:0] npc_q  [STAGES];

  // what each stage sees at its input (inputs for stage 0, previous stage otherwise)
  logic [STAGES-1:0] src_valid;
  logic [ACC_W-1:0]  src_opa  [STAGES];
  logic [DATA_W-1:0] src_opb  [STAGES];
  logic [ACC_W-1:0]  src_acc  [STAGES];
  logic [STAGES-1:0] src_hi;
  logic [TAG_W-1:0]  src_tag  [STAGES];
  logic [REG_W-1:0]  src_dest [STAGES];
  logic [DATA_W-1:0] src_npc  [STAGES];

  // result of one shift-and-add step applied to the stage input
  logic [ACC_W-1:0]  nxt_opa [STAGES];
  logic [DATA_W-1:0] nxt_opb [STAGES];
  logic [ACC_W-1:0]  nxt_acc [STAGES];

  logic [STAGES-1:0] adv;
  logic              in_ready_int;
  logic              accept;

  // advance chain, resolved from the output end back toward issue
  always_comb begin
    adv = '0;
    adv[L] = ~valid_q[L] | bus.out_ready;
    for (int i = L - 1; i >= 0; i--) begin
      adv[i] = ~valid_q[i] | adv[i+1];
    end
  end

  assign in_ready_int = adv[0] & ~bus.flush;
  assign accept       = bus.in_valid & in_ready_int;

  // route issue inputs into stage 0 and each register into the next stage
  always_comb begin
    src_valid   = '0;
    src_hi      = '0;
    src_valid[0] = accept;
    src_opa[0]   = ACC_W'(bus.in_opa);
    src_opb[0]   = bus.in_opb;
    src_acc[0]   = '0;
    src_hi[0]    = bus.in_hi;
    src_tag[0]   = bus.in_tag;
    src_dest[0]  = bus.in_dest_reg;
    src_npc[0]   = bus.in_npc;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = valid_q[i-1];
      src_opa[i]   = opa_q[i-1];
      src_opb[i]   = opb_q[i-1];
      src_acc[i]   = acc_q[i-1];
      src_hi[i]    = hi_q[i-1];
      src_tag[i]   = tag_q[i-1];
      src_dest[i]  = dest_q[i-1];
      src_npc[i]   = npc_q[i-1];
    end
  end

  // one partial-product step per stage, full width so nothing is lost before the end
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      nxt_acc[i] = src_acc[i] + (src_opa[i] * ACC_W'(src_opb[i][CHUNK-1:0]));
      nxt_opa[i] = src_opa[i] << CHUNK;
      nxt_opb[i] = src_opb[i] >> CHUNK;
    end
  end

  // valid bits: cleared by reset or flush, otherwise follow the advance chain
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) valid_q[i] <= src_valid[i];
      end
    end
  end

  // datapath fields load only when a live op moves in; otherwise they hold
  always_ff @(posedge clock) begin
    for (int i = 0; i < STAGES; i++) begin
      if (adv[i] && src_valid[i]) begin
        opa_q[i]  <= nxt_opa[i];
        opb_q[i]  <= nxt_opb[i];
        acc_q[i]  <= nxt_acc[i];
        hi_q[i]   <= src_hi[i];
        tag_q[i]  <= src_tag[i];
        dest_q[i] <= src_dest[i];
        npc_q[i]  <= src_npc[i];
      end
    end
  end

  assign bus.in_ready     = in_ready_int;
  assign bus.out_valid    = valid_q[L];
  assign bus.out_result   = !valid_q[L] ? '0 :
                            hi_q[L] ? acc_q[L][ACC_W-1:DATA_W] : acc_q[L][DATA_W-1:0];
  assign bus.out_tag      = valid_q[L] ? tag_q[L]  : '0;
  assign bus.out_dest_reg = valid_q[L] ? dest_q[L] : '0;
  assign bus.out_npc      = valid_q[L] ? npc_q[L]  : '0;
  assign bus.busy         = |valid_q;

endmodule
